// File: rtl/mult_sched_pkg.sv
// Shared widths and the tag type that follows each product through the
// multiplier pipeline.
package mult_sched_pkg;

  localparam int unsigned A_W = 10;
  localparam int unsigned B_W = 9;
  localparam int unsigned P_W = 19;

  // Sized for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/meu_multiplicador.sv
// Registered unsigned 10x9 multiplier shared by the scheduler's requesters.
module meu_multiplicador
  import mult_sched_pkg::*;
(
  input  logic           clk,
  input  logic [A_W-1:0] a_in,
  input  logic [B_W-1:0] b_in,
  output logic [P_W-1:0] p_out
);

  always_ff @(posedge clk) begin
    p_out <= P_W'(a_in) * P_W'(b_in);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int unsigned k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      k = (32'(ptr) + off) % NUM_REQ;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler time-sharing one pipelined multiplier between
// NUM_REQ requesters, returning each product to the requester that issued it.
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MULT_LAT = 1,
  parameter int unsigned ID_W     = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [A_W*NUM_REQ-1:0]          req_a,
  input  logic [B_W*NUM_REQ-1:0]          req_b,
  output logic [A_W-1:0]                  mult_a,
  output logic [B_W-1:0]                  mult_b,
  input  logic [P_W-1:0]                  mult_p,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [P_W-1:0]                  rsp_p,
  output logic [$clog2(MULT_LAT+2)-1:0]   inflight
);

  localparam int unsigned CNT_W = $clog2(MULT_LAT + 2);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               hs;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  // issue_tag_q lines up with mult_a/mult_b; trk_q[MULT_LAT-1] lines up with mult_p.
  tag_t issue_tag_q;
  tag_t trk_q [MULT_LAT];
  tag_t last_tag;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req  (req_valid),
    .ptr  (ptr_q),
    .grant(grant),
    .idx  (grant_idx),
    .any  (grant_any)
  );

  always_comb begin
    req_ready = rst_n ? grant : '0;
    hs        = rst_n & grant_any;
    ptr_d     = ptr_q;
    if (hs) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
    last_tag = trk_q[MULT_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
      issue_tag_q <= '0;
      for (int i = 0; i < int'(MULT_LAT); i++) begin
        trk_q[i] <= '0;
      end
      rsp_valid <= '0;
      rsp_p     <= '0;
      inflight  <= '0;
    end else begin
      ptr_q <= ptr_d;
      // Operands hold when idle to avoid needless toggling at the multiplier.
      if (hs) begin
        mult_a <= req_a[A_W*32'(grant_idx) +: A_W];
        mult_b <= req_b[B_W*32'(grant_idx) +: B_W];
      end
      issue_tag_q <= '{valid: hs, id: TAG_ID_W'(grant_idx)};
      trk_q[0]    <= issue_tag_q;
      for (int i = 1; i < int'(MULT_LAT); i++) begin
        trk_q[i] <= trk_q[i-1];
      end

      rsp_valid <= '0;
      if (last_tag.valid) begin
        rsp_valid <= NUM_REQ'(1) << last_tag.id;
        rsp_p     <= mult_p;
      end

      unique case ({hs, last_tag.valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched driving a real meu_multiplicador.
module tb_mult_share_sched;
  import mult_sched_pkg::*;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned MULT_LAT = 1;
  localparam int unsigned ID_W     = 2;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [A_W*NUM_REQ-1:0]      req_a;
  logic [B_W*NUM_REQ-1:0]      req_b;
  logic [A_W-1:0]              mult_a;
  logic [B_W-1:0]              mult_b;
  logic [P_W-1:0]              mult_p;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [P_W-1:0]              rsp_p;
  logic [$clog2(MULT_LAT+2)-1:0] inflight;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_share_sched #(
    .NUM_REQ (NUM_REQ),
    .MULT_LAT(MULT_LAT),
    .ID_W    (ID_W)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .mult_a   (mult_a),
    .mult_b   (mult_b),
    .mult_p   (mult_p),
    .rsp_valid(rsp_valid),
    .rsp_p    (rsp_p),
    .inflight (inflight)
  );

  meu_multiplicador u_mult (
    .clk  (clk),
    .a_in (mult_a),
    .b_in (mult_b),
    .p_out(mult_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    req_a[A_W*i +: A_W] = a;
    req_b[B_W*i +: B_W] = b;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    tick();
    tick();
    // Reset state; ready must stay low even with every request valid.
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_mult_a", 32'(mult_a), 32'h0);
    chk("rst_mult_b", 32'(mult_b), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_p", 32'(rsp_p), 32'h0);
    chk("rst_inflight", 32'(inflight), 32'h0);
    req_valid = '0;
    rst_n     = 1'b1;

    // Single request: 25 * 12 = 300.
    set_op(0, 10'd25, 9'd12);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("single_mult_a", 32'(mult_a), 32'd25);
    chk("single_mult_b", 32'(mult_b), 32'd12);
    chk("single_infl1", 32'(inflight), 32'd1);
    chk("single_rsp_early1", 32'(rsp_valid), 32'h0);
    tick();
    chk("single_infl2", 32'(inflight), 32'd1);
    chk("single_rsp_early2", 32'(rsp_valid), 32'h0);
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_p", 32'(rsp_p), 32'd300);
    chk("single_infl3", 32'(inflight), 32'd0);
    tick();
    chk("single_rsp_pulse", 32'(rsp_valid), 32'h0);

    // Reset so the rotation starts from pointer 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // All four valid: a = i+1, b = 2, grants rotate, products 2,4,6,8.
    for (int i = 0; i < 4; i++) set_op(i, A_W'(i + 1), 9'd2);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1) << (k % 4));
      tick();
      chk("rr_mult_a", 32'(mult_a), 32'((k % 4) + 1));
      chk("rr_mult_b", 32'(mult_b), 32'd2);
      if (k >= 1) chk("rr_inflight", 32'(inflight), 32'd2);
      if (k >= 2) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'(1) << ((k - 2) % 4));
        chk("rr_rsp_p", 32'(rsp_p), 32'(2 * (((k - 2) % 4) + 1)));
      end
    end
    req_valid = '0;
    tick();
    chk("rr_tail_valid6", 32'(rsp_valid), 32'h4);
    chk("rr_tail_p6", 32'(rsp_p), 32'd6);
    chk("rr_tail_infl6", 32'(inflight), 32'd1);
    tick();
    chk("rr_tail_valid7", 32'(rsp_valid), 32'h8);
    chk("rr_tail_p7", 32'(rsp_p), 32'd8);
    chk("rr_tail_infl7", 32'(inflight), 32'd0);

    // Pointer wrap: move ptr to 3 via requester 2, then 3 and 1 both valid.
    set_op(2, 10'd9, 9'd11);
    set_op(3, 10'd7, 9'd3);
    set_op(1, 10'd100, 9'd5);
    req_valid = 4'b0100;
    #1;
    chk("wrap_ready2", 32'(req_ready), 32'h4);
    tick();
    chk("wrap_ptr3", 32'(u_dut.ptr_q), 32'd3);
    req_valid = 4'b1010;
    #1;
    chk("wrap_ready3", 32'(req_ready), 32'h8);
    tick();
    chk("wrap_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    chk("wrap_ptr2", 32'(u_dut.ptr_q), 32'd2);
    chk("wrap_rsp2_valid", 32'(rsp_valid), 32'h4);
    chk("wrap_rsp2_p", 32'(rsp_p), 32'd99);
    tick();
    chk("wrap_rsp3_valid", 32'(rsp_valid), 32'h8);
    chk("wrap_rsp3_p", 32'(rsp_p), 32'd21);
    tick();
    chk("wrap_rsp1_valid", 32'(rsp_valid), 32'h2);
    chk("wrap_rsp1_p", 32'(rsp_p), 32'd500);

    // Max operands through requester 2 (ptr is 2): 1023 * 511 = 0x7FA01.
    set_op(2, 10'h3FF, 9'h1FF);
    req_valid = 4'b0100;
    #1;
    chk("max_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("max_mult_a", 32'(mult_a), 32'h3FF);
    chk("max_mult_b", 32'(mult_b), 32'h1FF);
    tick();
    tick();
    chk("max_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("max_rsp_p", 32'(rsp_p), 32'h7FA01);

    // Idle: nothing granted, operands and pointer held.
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_ready", 32'(req_ready), 32'h0);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("idle_mult_a", 32'(mult_a), 32'h3FF);
      chk("idle_mult_b", 32'(mult_b), 32'h1FF);
    end
    chk("idle_ptr", 32'(u_dut.ptr_q), 32'd3);

    // Reset mid-flight: grants to 3 then 0, then reset kills both products.
    set_op(0, 10'd5, 9'd5);
    set_op(3, 10'd6, 9'd6);
    req_valid = 4'b1001;
    #1;
    chk("mid_ready3", 32'(req_ready), 32'h8);
    tick();
    chk("mid_ready0", 32'(req_ready), 32'h1);
    tick();
    chk("mid_infl", 32'(inflight), 32'd2);
    req_valid = 4'b1111;
    rst_n     = 1'b0;
    #1;
    chk("mid_ready_in_rst", 32'(req_ready), 32'h0);
    tick();
    req_valid = '0;
    rst_n     = 1'b1;
    chk("mid_ptr", 32'(u_dut.ptr_q), 32'd0);
    chk("mid_infl_rst", 32'(inflight), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
      chk("mid_infl_post", 32'(inflight), 32'd0);
      tick();
    end
    req_valid = 4'b1111;
    #1;
    chk("mid_next_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
